// File: rtl/hilo_muldiv_ctrl_pkg.sv
// Shared definitions for the HI/LO multiply/divide sequencer: op encodings,
// FSM state encodings and the divide step count.
package hilo_muldiv_ctrl_pkg;

    typedef enum logic [2:0] {
        OP_MULT  = 3'b000,
        OP_MULTU = 3'b001,
        OP_DIV   = 3'b010,
        OP_DIVU  = 3'b011,
        OP_MTHI  = 3'b100,
        OP_MTLO  = 3'b101,
        OP_MADD  = 3'b110,
        OP_MSUB  = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_DIV  = 2'b10,
        ST_DONE = 2'b11
    } state_e;

    localparam int DIV_STEPS = 32;

    // Plain multiplies that go through the MUL latency path.
    function automatic logic is_mul_op(input op_e op);
        return (op == OP_MULT) || (op == OP_MULTU);
    endfunction

    // Both divide flavours share the restoring divider.
    function automatic logic is_div_op(input op_e op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/hilo_muldiv_ctrl_div_iter.sv
// Radix-2 restoring divider datapath working on unsigned magnitudes.
// One quotient bit per step; o_quo/o_rem show the value after the current
// step so the owner can capture the final result on the last step's edge.
module hilo_muldiv_ctrl_div_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic             i_step,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH-1:0] o_quo,
    output logic [WIDTH-1:0] o_rem
);

    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_dvs;
    logic [WIDTH:0]   w_trial;
    logic [WIDTH-1:0] w_rem_nxt;
    logic [WIDTH-1:0] w_quo_nxt;

    assign w_trial = {r_rem, r_quo[WIDTH-1]} - {1'b0, r_dvs};

    // Trial subtract: keep the difference when it does not borrow, else restore.
    always_comb begin
        w_rem_nxt = {r_rem[WIDTH-2:0], r_quo[WIDTH-1]};
        w_quo_nxt = {r_quo[WIDTH-2:0], 1'b0};
        if (!w_trial[WIDTH]) begin
            w_rem_nxt = w_trial[WIDTH-1:0];
            w_quo_nxt = {r_quo[WIDTH-2:0], 1'b1};
        end
    end

    // Partial remainder starts at zero; dividend bits shift in through r_quo.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rem <= '0;
            r_quo <= '0;
            r_dvs <= '0;
        end else if (i_load) begin
            r_rem <= '0;
            r_quo <= i_dividend;
            r_dvs <= i_divisor;
        end else if (i_step) begin
            r_rem <= w_rem_nxt;
            r_quo <= w_quo_nxt;
        end
    end

    assign o_quo = w_quo_nxt;
    assign o_rem = w_rem_nxt;

endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// HI/LO writer sequencer: MTHI/MTLO write next cycle, multiplies wait
// MUL_LAT cycles, divides run DIV_STEPS restoring steps, then one DONE
// cycle drives the registered write strobes and data.
// Optional feature macro HILO_MADD_EN enables MADD/MSUB (signed accumulate
// into the HI/LO value sampled at accept); without it ops 110/111 do nothing.
module hilo_muldiv_ctrl
    import hilo_muldiv_ctrl_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic [WIDTH-1:0] hi_i,
    input  logic [WIDTH-1:0] lo_i,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic             we_hi,
    output logic             we_lo,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = ($clog2(MUL_LAT) > $clog2(DIV_STEPS)) ? $clog2(MUL_LAT) : $clog2(DIV_STEPS);

    state_e             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_signed;
    logic               r_div_zero;
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_done;
    logic               r_we_hi;
    logic               r_we_lo;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    op_e                w_op;
    logic               w_is_mul;
    logic               w_is_div;
    logic               w_is_acc;
    logic               w_accept;
    logic               w_div_signed;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic [WIDTH-1:0]   w_q_mag;
    logic [WIDTH-1:0]   w_r_mag;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;
    logic [2*WIDTH-1:0] w_a_ext;
    logic [2*WIDTH-1:0] w_b_ext;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_mul_res;

    assign w_op     = op_e'(op);
    assign w_is_mul = is_mul_op(w_op);
    assign w_is_div = is_div_op(w_op);
    assign w_accept = (r_state == ST_IDLE) && start && !flush;

    assign busy = (w_accept && (w_is_mul || w_is_div || w_is_acc)) ||
                  (r_state == ST_MUL) || (r_state == ST_DIV);

    // The divider only ever sees magnitudes; signs are restored on the way out.
    assign w_div_signed = (w_op == OP_DIV);
    assign w_abs_a = (w_div_signed && src_a[WIDTH-1]) ? -src_a : src_a;
    assign w_abs_b = (w_div_signed && src_b[WIDTH-1]) ? -src_b : src_b;

    assign w_quo = r_div_zero ? '1  : (r_neg_q ? -w_q_mag : w_q_mag);
    assign w_rem = r_div_zero ? r_a : (r_neg_r ? -w_r_mag : w_r_mag);

    // Sign- or zero-extending both operands makes one 2W-bit multiply serve both flavours.
    assign w_a_ext = {{WIDTH{r_signed & r_a[WIDTH-1]}}, r_a};
    assign w_b_ext = {{WIDTH{r_signed & r_b[WIDTH-1]}}, r_b};
    assign w_prod  = w_a_ext * w_b_ext;

`ifdef HILO_MADD_EN
    logic [WIDTH-1:0] r_acc_hi;
    logic [WIDTH-1:0] r_acc_lo;
    logic             r_sub;

    assign w_is_acc  = (w_op == OP_MADD) || (w_op == OP_MSUB);
    assign w_mul_res = r_sub ? ({r_acc_hi, r_acc_lo} - w_prod) : ({r_acc_hi, r_acc_lo} + w_prod);
`else
    logic w_unused_acc;

    assign w_is_acc     = 1'b0;
    assign w_mul_res    = w_prod;
    assign w_unused_acc = ^{hi_i, lo_i};
`endif

    hilo_muldiv_ctrl_div_iter #(
        .WIDTH (WIDTH)
    ) u_div_iter (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_accept && w_is_div),
        .i_step     ((r_state == ST_DIV) && !flush),
        .i_dividend (w_abs_a),
        .i_divisor  (w_abs_b),
        .o_quo      (w_q_mag),
        .o_rem      (w_r_mag)
    );

    // Sequencer FSM; write strobes are registered so they cover a full cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_signed   <= 1'b0;
            r_div_zero <= 1'b0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_done     <= 1'b0;
            r_we_hi    <= 1'b0;
            r_we_lo    <= 1'b0;
            r_hi       <= '0;
            r_lo       <= '0;
`ifdef HILO_MADD_EN
            r_acc_hi   <= '0;
            r_acc_lo   <= '0;
            r_sub      <= 1'b0;
`endif
        end else begin
            r_done  <= 1'b0;
            r_we_hi <= 1'b0;
            r_we_lo <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_a   <= src_a;
                        r_b   <= src_b;
                        r_cnt <= '0;
                        if (w_op == OP_MTHI) begin
                            r_we_hi <= 1'b1;
                            r_hi    <= src_a;
                        end else if (w_op == OP_MTLO) begin
                            r_we_lo <= 1'b1;
                            r_lo    <= src_a;
                        end else if (w_is_mul || w_is_acc) begin
                            r_signed <= (w_op != OP_MULTU);
                            r_state  <= ST_MUL;
`ifdef HILO_MADD_EN
                            r_acc_hi <= w_is_acc ? hi_i : '0;
                            r_acc_lo <= w_is_acc ? lo_i : '0;
                            r_sub    <= (w_op == OP_MSUB);
`endif
                        end else if (w_is_div) begin
                            r_div_zero <= (src_b == '0);
                            r_neg_q    <= w_div_signed && (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
                            r_neg_r    <= w_div_signed && src_a[WIDTH-1];
                            r_state    <= ST_DIV;
                        end
                    end
                end
                ST_MUL: begin
                    if (flush) begin
                        r_state <= ST_IDLE;
                    end else if (r_cnt == CNT_W'(MUL_LAT - 1)) begin
                        r_state      <= ST_DONE;
                        r_done       <= 1'b1;
                        r_we_hi      <= 1'b1;
                        r_we_lo      <= 1'b1;
                        {r_hi, r_lo} <= w_mul_res;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_DIV: begin
                    if (flush) begin
                        r_state <= ST_IDLE;
                    end else if (r_cnt == CNT_W'(DIV_STEPS - 1)) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                        r_we_hi <= 1'b1;
                        r_we_lo <= 1'b1;
                        r_hi    <= w_rem;
                        r_lo    <= w_quo;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign done  = r_done;
    assign we_hi = r_we_hi;
    assign we_lo = r_we_lo;
    assign hi    = r_hi;
    assign lo    = r_lo;

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Self-checking bench for hilo_muldiv_ctrl: directed cases plus random ops
// compared against an arithmetic reference of the HI/LO results and timing.
// Honours HILO_MADD_EN the same way the design does.
module tb_hilo_muldiv_ctrl;

    localparam int MUL_LAT = 2;
    localparam int DIV_LAT = 33;

    logic        clk;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic [31:0] hi_i;
    logic [31:0] lo_i;
    logic        flush;
    logic        busy;
    logic        done;
    logic        we_hi;
    logic        we_lo;
    logic [31:0] hi;
    logic [31:0] lo;

    int          nCompared   = 0;
    int          nMismatched = 0;
    logic [31:0] expHi = '0;
    logic [31:0] expLo = '0;

    hilo_muldiv_ctrl #(
        .WIDTH   (32),
        .MUL_LAT (MUL_LAT)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .src_a (src_a),
        .src_b (src_b),
        .hi_i  (hi_i),
        .lo_i  (lo_i),
        .flush (flush),
        .busy  (busy),
        .done  (done),
        .we_hi (we_hi),
        .we_lo (we_lo),
        .hi    (hi),
        .lo    (lo)
    );

    // Free-running 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case the sequence ever stalls.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog expired nCompared=%0d", nCompared);
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nCompared++;
        assert (observed === expected) else begin
            nMismatched++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] flags();
        return {28'd0, busy, done, we_hi, we_lo};
    endfunction

    // Reference: result words and latency straight from the op definitions.
    task automatic predict(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] hin, input logic [31:0] lin,
                           output int lat, output logic isLong, output logic wantHi,
                           output logic wantLo, output logic [63:0] res);
        longint sa;
        longint sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        isLong = 1'b1;
        wantHi = 1'b1;
        wantLo = 1'b1;
        lat    = MUL_LAT + 1;
        res    = '0;
        case (o)
            3'd0: res = 64'(sa * sb);
            3'd1: res = {32'd0, a} * {32'd0, b};
            3'd2: begin
                lat = DIV_LAT;
                if (b == 0) res = {a, 32'hFFFF_FFFF};
                else        res = {32'(sa % sb), 32'(sa / sb)};
            end
            3'd3: begin
                lat = DIV_LAT;
                if (b == 0) res = {a, 32'hFFFF_FFFF};
                else        res = {a % b, a / b};
            end
            3'd4: begin
                isLong = 1'b0; wantLo = 1'b0; lat = 1; res = {a, 32'd0};
            end
            3'd5: begin
                isLong = 1'b0; wantHi = 1'b0; lat = 1; res = {32'd0, a};
            end
            default: begin
`ifdef HILO_MADD_EN
                if (o == 3'd6) res = {hin, lin} + 64'(sa * sb);
                else           res = {hin, lin} - 64'(sa * sb);
`else
                isLong = 1'b0; wantHi = 1'b0; wantLo = 1'b0; lat = 1;
`endif
            end
        endcase
    endtask

    // Issue one op, scramble ignored inputs while stalled, check the write and the hold after it.
    task automatic applyStimulus(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] hin, input logic [31:0] lin, input string tag);
        int          lat;
        logic        isLong;
        logic        wantHi;
        logic        wantLo;
        logic [63:0] res;
        predict(o, a, b, hin, lin, lat, isLong, wantHi, wantLo, res);
        start = 1'b1; op = o; src_a = a; src_b = b; hi_i = hin; lo_i = lin; flush = 1'b0;
        #1;
        checkOutput({tag, "/busyAccept"}, {31'd0, busy}, {31'd0, isLong});
        for (int c = 1; c <= lat; c++) begin
            tick();
            if (c < lat) begin
                start = 1'($urandom_range(0, 1));
                op    = 3'($urandom_range(0, 7));
                src_a = $urandom; src_b = $urandom; hi_i = $urandom; lo_i = $urandom;
                #1;
                checkOutput({tag, "/wait"}, flags(), 32'h8);
            end else begin
                start = 1'b0;
                if (isLong) flush = 1'($urandom_range(0, 1));
                #1;
                if (wantHi) expHi = res[63:32];
                if (wantLo) expLo = res[31:0];
                checkOutput({tag, "/write"}, flags(), {28'd0, 1'b0, isLong, wantHi, wantLo});
                checkOutput({tag, "/hi"}, hi, expHi);
                checkOutput({tag, "/lo"}, lo, expLo);
            end
        end
        tick();
        flush = 1'b0;
        #1;
        checkOutput({tag, "/after"}, flags(), 32'h0);
        checkOutput({tag, "/holdHi"}, hi, expHi);
        checkOutput({tag, "/holdLo"}, lo, expLo);
    endtask

    initial begin
        logic [2:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;

        rst = 1'b0; start = 1'b0; op = '0; src_a = '0; src_b = '0;
        hi_i = '0; lo_i = '0; flush = 1'b0;
        repeat (2) tick();
        checkOutput("reset/flags", flags(), 32'h0);
        checkOutput("reset/hi", hi, 32'h0);
        checkOutput("reset/lo", lo, 32'h0);
        rst = 1'b1;
        tick();

        $display("[TB] directed ops");
        applyStimulus(3'd0, 32'hFFFF_FFFF, 32'h2, 32'h0, 32'h0, "MULT");
        applyStimulus(3'd1, 32'hFFFF_FFFF, 32'h2, 32'h0, 32'h0, "MULTU");
        applyStimulus(3'd2, 32'hFFFF_FFF9, 32'h2, 32'h0, 32'h0, "DIVneg");
        applyStimulus(3'd3, 32'h0000_1234, 32'h0, 32'h0, 32'h0, "DIVUzero");
        applyStimulus(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h0, "DIVovf");
        applyStimulus(3'd2, 32'h0000_0064, 32'h0, 32'h0, 32'h0, "DIVzero");
        applyStimulus(3'd4, 32'hDEAD_BEEF, 32'h0, 32'h0, 32'h0, "MTHI");
        applyStimulus(3'd6, 32'h2, 32'h3, 32'h0, 32'h5, "MADD");
        applyStimulus(3'd7, 32'h7, 32'hFFFF_FFFD, 32'h1, 32'h0, "MSUB");

        $display("[TB] flush while idle blocks accept");
        start = 1'b1; op = 3'd0; src_a = 32'h3; src_b = 32'h4; flush = 1'b1;
        #1;
        checkOutput("flushIdle/busy", flags(), 32'h0);
        tick();
        start = 1'b0; flush = 1'b0;
        #1;
        checkOutput("flushIdle/T1", flags(), 32'h0);
        tick();
        checkOutput("flushIdle/T2", flags(), 32'h0);

        $display("[TB] flush during divide");
        start = 1'b1; op = 3'd2; src_a = 32'd1000; src_b = 32'd7;
        #1;
        checkOutput("flushDiv/busyT", flags(), 32'h8);
        tick();
        start = 1'b0;
        repeat (9) tick();
        flush = 1'b1;
        #1;
        checkOutput("flushDiv/busyT10", flags(), 32'h8);
        tick();
        flush = 1'b0;
        #1;
        checkOutput("flushDiv/T11", flags(), 32'h0);
        for (int i = 0; i < 25; i++) begin
            tick();
            checkOutput("flushDiv/quiet", flags(), 32'h0);
        end
        checkOutput("flushDiv/hi", hi, expHi);
        checkOutput("flushDiv/lo", lo, expLo);
        applyStimulus(3'd0, 32'h0001_0001, 32'hFFFF_0003, 32'h0, 32'h0, "MULTafterFlush");

        $display("[TB] reset during divide");
        start = 1'b1; op = 3'd2; src_a = $urandom; src_b = 32'd3;
        tick();
        start = 1'b0;
        repeat (9) tick();
        rst = 1'b0;
        #1;
        expHi = '0;
        expLo = '0;
        checkOutput("midReset/flags", flags(), 32'h0);
        checkOutput("midReset/hi", hi, 32'h0);
        checkOutput("midReset/lo", lo, 32'h0);
        repeat (2) tick();
        rst = 1'b1;
        for (int i = 0; i < 30; i++) begin
            tick();
            checkOutput("midReset/quiet", flags(), 32'h0);
        end
        applyStimulus(3'd5, 32'h5, 32'h0, 32'h0, 32'h0, "MTLOafterReset");

        $display("[TB] random ops");
        for (int n = 0; n < 24; n++) begin
            ro = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 5))
                0: rb = 32'h0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: rb = 32'($urandom_range(1, 15));
                default: ;
            endcase
            applyStimulus(ro, ra, rb, $urandom, $urandom, "random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
